// File: rtl/matvec_row_sequencer_pkg.sv
// Shared definitions for the matrix-vector row sequencer and its dot_product partner.
// Holds state encodings, size defaults and the row/length legality check.
package matvec_row_sequencer_pkg;

    localparam int DATA_WIDTH_DEF      = 32;
    localparam int MAX_VECTOR_SIZE_DEF = 7;
    localparam int LEN_WIDTH           = 4;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CHECK    = 4'd1,
        S_FETCH    = 4'd2,
        S_DRAIN    = 4'd3,
        S_DP_START = 4'd4,
        S_DP_WAIT  = 4'd5,
        S_DP_ACK   = 4'd6,
        S_EMIT     = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // Same rule the dot_product instance applies to its vector_length input.
    function automatic logic lengths_legal(input logic [LEN_WIDTH-1:0] num_rows,
                                           input logic [LEN_WIDTH-1:0] vec_len,
                                           input int                   max_len);
        return (num_rows != '0) && (vec_len != '0) && (int'(vec_len) <= max_len);
    endfunction

endpackage

// File: rtl/matvec_row_sequencer_row_packer.sv
// Packs one weight row from the synchronous weight memory into a flat vector.
// Read data lands one cycle after the strobe and is written to the next slot.
module matvec_row_sequencer_row_packer
    import matvec_row_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_VECTOR_SIZE = MAX_VECTOR_SIZE_DEF
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  clear,
    input  logic                                  rewind,
    input  logic                                  rd_en,
    input  logic [DATA_WIDTH-1:0]                 rd_data,
    output logic [DATA_WIDTH*MAX_VECTOR_SIZE-1:0] vector_flat
);

    localparam int IDX_W = (MAX_VECTOR_SIZE > 1) ? $clog2(MAX_VECTOR_SIZE) : 1;

    logic             rd_valid;
    logic [IDX_W-1:0] widx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid    <= 1'b0;
            widx        <= '0;
            vector_flat <= '0;
        end else begin
            rd_valid <= rd_en;
            if (clear) begin
                vector_flat <= '0;
                widx        <= '0;
            end else if (rewind) begin
                widx <= '0;
            end else if (rd_valid) begin
                for (int i = 0; i < MAX_VECTOR_SIZE; i++) begin
                    if (widx == IDX_W'(i)) begin
                        vector_flat[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                    end
                end
                widx <= widx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matvec_row_sequencer.sv
// Fetches weight rows for one matrix-vector product and runs the dot_product handshake,
// emitting one scalar result per row.
//   state      | meaning
//   S_IDLE     | wait for start, latch job inputs
//   S_CHECK    | validate lengths, prime first row fetch
//   S_FETCH    | issue vec_len weight reads
//   S_DRAIN    | last read data lands in the packer
//   S_DP_START | raise dp_start
//   S_DP_WAIT  | hold dp_start until dp_done, capture result
//   S_DP_ACK   | wait for dp_done to fall
//   S_EMIT     | row_valid pulse, next row or finish
//   S_DONE     | done high until start drops
module matvec_row_sequencer
    import matvec_row_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_VECTOR_SIZE = MAX_VECTOR_SIZE_DEF,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    output logic                                  done,
    output logic                                  err,
    input  logic [3:0]                            num_rows,
    input  logic [3:0]                            vec_len,
    input  logic [ADDR_WIDTH-1:0]                 w_base_addr,
    input  logic [DATA_WIDTH*MAX_VECTOR_SIZE-1:0] x_vector_flat,
    output logic                                  w_rd_en,
    output logic [ADDR_WIDTH-1:0]                 w_rd_addr,
    input  logic [DATA_WIDTH-1:0]                 w_rd_data,
    output logic                                  dp_start,
    input  logic                                  dp_done,
    output logic [DATA_WIDTH*MAX_VECTOR_SIZE-1:0] dp_vector_a_flat,
    output logic [DATA_WIDTH*MAX_VECTOR_SIZE-1:0] dp_vector_b_flat,
    output logic [3:0]                            dp_vector_length,
    input  logic [DATA_WIDTH-1:0]                 dp_result,
    output logic                                  row_valid,
    output logic [3:0]                            row_index,
    output logic [DATA_WIDTH-1:0]                 row_result
);

    state_t     state;
    logic [3:0] num_rows_q;
    logic [3:0] row;
    logic [3:0] issue_cnt;

    matvec_row_sequencer_row_packer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .MAX_VECTOR_SIZE (MAX_VECTOR_SIZE)
    ) u_row_packer (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (state == S_CHECK),
        .rewind      (state == S_EMIT),
        .rd_en       (w_rd_en),
        .rd_data     (w_rd_data),
        .vector_flat (dp_vector_a_flat)
    );

    // w_rd_addr doubles as the running row address; it is never rewound between rows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= S_IDLE;
            num_rows_q       <= '0;
            row              <= '0;
            issue_cnt        <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
            w_rd_en          <= 1'b0;
            w_rd_addr        <= '0;
            dp_start         <= 1'b0;
            dp_vector_b_flat <= '0;
            dp_vector_length <= '0;
            row_valid        <= 1'b0;
            row_index        <= '0;
            row_result       <= '0;
        end else begin
            row_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_rows_q       <= num_rows;
                        dp_vector_length <= vec_len;
                        w_rd_addr        <= w_base_addr;
                        dp_vector_b_flat <= x_vector_flat;
                        err              <= 1'b0;
                        state            <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!lengths_legal(num_rows_q, dp_vector_length, MAX_VECTOR_SIZE)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        row       <= '0;
                        w_rd_en   <= 1'b1;
                        issue_cnt <= dp_vector_length;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    w_rd_addr <= w_rd_addr + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                    if (issue_cnt == 4'd1) begin
                        w_rd_en <= 1'b0;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    dp_start <= 1'b1;
                    state    <= S_DP_START;
                end
                S_DP_START: begin
                    state <= S_DP_WAIT;
                end
                S_DP_WAIT: begin
                    if (dp_done) begin
                        row_result <= dp_result;
                        row_index  <= row;
                        dp_start   <= 1'b0;
                        state      <= S_DP_ACK;
                    end
                end
                S_DP_ACK: begin
                    if (!dp_done) begin
                        row_valid <= 1'b1;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (row == num_rows_q - 4'd1) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        row       <= row + 1'b1;
                        w_rd_en   <= 1'b1;
                        issue_cnt <= dp_vector_length;
                        state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_row_sequencer.sv
// Randomised bench for matvec_row_sequencer with a weight memory, a dot_product stand-in
// and a reference model built from plain address/sum arithmetic.
module tb_matvec_row_sequencer;

    localparam int DW = 32;
    localparam int MV = 7;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              done, err;
    logic [3:0]        num_rows = '0;
    logic [3:0]        vec_len = '0;
    logic [AW-1:0]     w_base_addr = '0;
    logic [DW*MV-1:0]  x_vector_flat = '0;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic [DW-1:0]     w_rd_data = '0;
    logic              dp_start;
    logic              dp_done;
    logic [DW*MV-1:0]  dp_vector_a_flat, dp_vector_b_flat;
    logic [3:0]        dp_vector_length;
    logic [DW-1:0]     dp_result;
    logic              row_valid;
    logic [3:0]        row_index;
    logic [DW-1:0]     row_result;

    matvec_row_sequencer #(.DATA_WIDTH(DW), .MAX_VECTOR_SIZE(MV), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .done(done), .err(err),
        .num_rows(num_rows), .vec_len(vec_len), .w_base_addr(w_base_addr),
        .x_vector_flat(x_vector_flat), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .dp_start(dp_start), .dp_done(dp_done),
        .dp_vector_a_flat(dp_vector_a_flat), .dp_vector_b_flat(dp_vector_b_flat),
        .dp_vector_length(dp_vector_length), .dp_result(dp_result),
        .row_valid(row_valid), .row_index(row_index), .row_result(row_result)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Weight memory: synchronous read, data one cycle after the strobe.
    logic [DW-1:0] mem [256];
    always @(posedge clk) if (w_rd_en) w_rd_data <= mem[w_rd_addr];

    // Current job, as seen by the reference model.
    int          j_nr, j_vl, j_base;
    logic [DW*MV-1:0] j_x;
    int          dp_lat = 1;
    int          dp_hold = 0;

    function automatic logic [AW-1:0] exp_addr(int r, int k);
        return AW'((j_base + r * j_vl + k) % 256);
    endfunction

    function automatic logic [DW*MV-1:0] exp_row_vec(int r);
        logic [DW*MV-1:0] v = '0;
        for (int k = 0; k < j_vl; k++) v[k*DW +: DW] = mem[exp_addr(r, k)];
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_dot(int r);
        logic [DW-1:0] s = '0;
        for (int k = 0; k < j_vl; k++) s = s + mem[exp_addr(r, k)] * j_x[k*DW +: DW];
        return s;
    endfunction

    function automatic logic [DW-1:0] engine_dot();
        logic [DW-1:0] s = '0;
        for (int k = 0; k < MV; k++)
            if (k < int'(dp_vector_length))
                s = s + dp_vector_a_flat[k*DW +: DW] * dp_vector_b_flat[k*DW +: DW];
        return s;
    endfunction

    // dot_product stand-in: done after dp_lat cycles, held dp_hold cycles after start falls.
    int dp_ph = 0;
    int dp_cnt = 0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_done   <= 1'b0;
            dp_result <= '0;
            dp_ph = 0;
        end else begin
            case (dp_ph)
                0: if (dp_start) begin dp_cnt = dp_lat; dp_ph = 1; end
                1: if (dp_cnt == 0) begin
                       dp_done   <= 1'b1;
                       dp_result <= engine_dot();
                       dp_ph = 2;
                   end else dp_cnt--;
                2: if (!dp_start) begin dp_cnt = dp_hold; dp_ph = 3; end
                default: if (dp_cnt == 0) begin dp_done <= 1'b0; dp_ph = 0; end
                         else dp_cnt--;
            endcase
        end
    end

    logic [AW-1:0] rd_q[$];
    int            idx_q[$];
    logic [DW-1:0] res_q[$];
    int n_rd = 0, n_dps = 0, dp_rows = 0;
    logic dp_start_d = 1'b0, row_valid_d = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            dp_start_d  = 1'b0;
            row_valid_d = 1'b0;
        end else begin
            if (w_rd_en) begin rd_q.push_back(w_rd_addr); n_rd++; end
            if (dp_start) n_dps++;
            if (dp_start && !dp_start_d) begin
                check_val("dp_start_rise_done_low", dp_done, 0);
                check_val($sformatf("vec_a_row%0d", dp_rows), dp_vector_a_flat, exp_row_vec(dp_rows));
                check_val("vec_b", dp_vector_b_flat, j_x);
                dp_rows++;
            end
            if (row_valid) begin
                check_val("row_valid_dp_done_low", dp_done, 0);
                check_val("row_valid_single", row_valid_d, 0);
                idx_q.push_back(int'(row_index));
                res_q.push_back(row_result);
            end
            dp_start_d  = dp_start;
            row_valid_d = row_valid;
        end
    end

    task automatic setup_job(input int nr, input int vl, input int base, input int lat,
                             input int hold, input bit randmem);
        if (randmem) for (int i = 0; i < 256; i++) mem[i] = $urandom;
        j_nr = nr; j_vl = vl; j_base = base;
        for (int k = 0; k < MV; k++) j_x[k*DW +: DW] = $urandom;
        dp_lat = lat; dp_hold = hold;
        rd_q.delete(); idx_q.delete(); res_q.delete();
        n_rd = 0; n_dps = 0; dp_rows = 0;
        num_rows = 4'(nr); vec_len = 4'(vl); w_base_addr = AW'(base);
        x_vector_flat = j_x;
        start = 1'b1;
    endtask

    task automatic run_job(input int nr, input int vl, input int base, input int lat,
                           input int hold, input bit randmem);
        int cyc;
        bit exp_err;
        int snap_rd, snap_dps;
        exp_err = (nr == 0) || (vl == 0) || (vl > MV);
        setup_job(nr, vl, base, lat, hold, randmem);
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        check_val("done_reached", done, 1);
        check_val("err", err, exp_err);
        if (exp_err) begin
            check_val("err_latency_le2", cyc <= 2, 1);
            check_val("err_no_rd", n_rd, 0);
            check_val("err_no_dp_start", n_dps, 0);
        end else begin
            check_val("rd_count", rd_q.size(), nr * vl);
            for (int i = 0; i < rd_q.size() && i < nr * vl; i++)
                check_val($sformatf("rd_addr%0d", i), rd_q[i], exp_addr(i / vl, i % vl));
            check_val("row_count", idx_q.size(), nr);
            for (int r = 0; r < idx_q.size() && r < nr; r++) begin
                check_val($sformatf("row_index%0d", r), idx_q[r], r);
                check_val($sformatf("row_result%0d", r), res_q[r], exp_dot(r));
            end
        end
        snap_rd = n_rd; snap_dps = n_dps;
        repeat (4) @(negedge clk);
        check_val("done_held_with_start", done, 1);
        check_val("no_restart_rd", n_rd, snap_rd);
        check_val("no_restart_dp", n_dps, snap_dps);
        start = 1'b0;
        @(negedge clk);
        check_val("done_clears", done, 0);
        check_val("err_holds", err, exp_err);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        logic [DW-1:0] a, b, c;
        repeat (3) @(negedge clk);
        check_val("rst_outputs", {done, err, w_rd_en, w_rd_addr, dp_start, row_valid,
                                  row_index, row_result, dp_vector_length}, 0);
        check_val("rst_vec_a", dp_vector_a_flat, 0);
        check_val("rst_vec_b", dp_vector_b_flat, 0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("idle_done", done, 0);

        // single row, directed weights A,B,C at 0x10
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        a = $urandom; b = $urandom; c = $urandom;
        mem[8'h10] = a; mem[8'h11] = b; mem[8'h12] = c;
        run_job(1, 3, 'h10, 2, 0, 1'b0);
        check_val("single_vec_a", dp_vector_a_flat, {{(4*DW){1'b0}}, c, b, a});

        run_job(3, 7, 0, 2, 0, 1'b1);         // contiguous multi-row
        run_job(1, 4, 'hFE, 1, 0, 1'b1);      // address wrap
        run_job(1, 0, 5, 1, 0, 1'b1);         // illegal lengths
        run_job(1, 8, 5, 1, 0, 1'b1);
        run_job(0, 3, 5, 1, 0, 1'b1);
        run_job(2, 3, 'h40, 3, 5, 1'b1);      // slow dp_done release
        repeat (6) run_job($urandom_range(1, 4), $urandom_range(1, 7), $urandom_range(0, 255),
                           $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);

        // reset while waiting on row 1 of 3
        setup_job(3, 5, 'h20, 8, 0, 1'b1);
        cyc = 0;
        while (!(idx_q.size() == 1 && dp_start && !dp_done) && cyc < 1000) begin
            @(negedge clk); cyc++;
        end
        check_val("reset_point_reached", idx_q.size() == 1 && dp_start && !dp_done, 1);
        #2 rstn = 1'b0;
        #1;
        check_val("midrst_outputs", {done, err, w_rd_en, w_rd_addr, dp_start, row_valid,
                                     row_index, row_result, dp_vector_length}, 0);
        check_val("midrst_vec_a", dp_vector_a_flat, 0);
        check_val("midrst_vec_b", dp_vector_b_flat, 0);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_job(2, 6, 'h33, 2, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matvec_row_sequencer.md
Name: matvec_row_sequencer

Overview:
- Upstream sequencer for the dot_product engine in the GRU datapath. For one matrix-vector product it fetches each weight row from a synchronous weight memory and packs it into flat vectors. It drives the dot_product start/done handshake and emits one scalar result per row.
- Gate/candidate logic downstream consumes the row results. The result word format is opaque to this block.

Parameters:
- DATA_WIDTH, 32, width of one vector element and of each row result.
- MAX_VECTOR_SIZE, 7, maximum row length. Must match the dot_product instance.
- ADDR_WIDTH, 8, weight memory address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- start  in  1  level request. Sampled in IDLE only.
- done  out  1  high in DONE until start is low.
- err  out  1  set with done when lengths are illegal.
- num_rows  in  4  rows to process, 1..15. Sampled at start.
- vec_len  in  4  elements per row, 1..MAX_VECTOR_SIZE. Sampled at start.
- w_base_addr  in  ADDR_WIDTH  address of row 0, element 0. Sampled at start.
- x_vector_flat  in  DATA_WIDTH*MAX_VECTOR_SIZE  input/hidden vector. Captured at start.
- w_rd_en  out  1  weight memory read strobe.
- w_rd_addr  out  ADDR_WIDTH  weight read address.
- w_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after w_rd_en.
- dp_start  out  1  to dot_product start.
- dp_done  in  1  from dot_product done.
- dp_vector_a_flat  out  DATA_WIDTH*MAX_VECTOR_SIZE  packed weight row.
- dp_vector_b_flat  out  DATA_WIDTH*MAX_VECTOR_SIZE  captured x vector.
- dp_vector_length  out  4  vec_len latched.
- dp_result  in  DATA_WIDTH  dot_product result, valid while dp_done is high.
- row_valid  out  1  one-cycle pulse per completed row.
- row_index  out  4  row number of row_result.
- row_result  out  DATA_WIDTH  result for row_index.

Behaviour:
- Reset is asynchronous, active-low (rstn); clock is clk.
- Reset values: all outputs 0 and all internal vectors 0; state IDLE. Reset mid-operation abandons the job and drops dp_start immediately.
- IDLE:
  - start=1 latches num_rows, vec_len, w_base_addr and x_vector_flat, and clears err. Go to CHECK.
  - start while not in IDLE is ignored.
- CHECK: if num_rows==0, vec_len==0 or vec_len>MAX_VECTOR_SIZE, set err=1, go to DONE, issue no read and no dp_start. Otherwise row=0, addr=w_base_addr, clear dp_vector_a_flat, go to FETCH.
- FETCH:
  - Asserts w_rd_en for vec_len consecutive cycles; element k of the row is read from addr+k.
  - addr accumulates across rows: row r element k = w_base_addr + r*vec_len + k, modulo 2^ADDR_WIDTH (wraps silently).
  - Data returning one cycle later is written to slot k of dp_vector_a_flat. Slots >= vec_len stay 0.
  - After the last issue, go to DRAIN.
- DRAIN: captures the final element, w_rd_en=0, go to DP_START.
- DP_START: dp_start=1, go to DP_WAIT.
- DP_WAIT:
  - dp_start is held high.
  - When dp_done=1: capture row_result<=dp_result and row_index<=row, drop dp_start, go to DP_ACK.
- DP_ACK: dp_start=0. Wait for dp_done=0, then go to EMIT.
- EMIT:
  - row_valid=1 for this cycle only.
  - If row==num_rows-1, go to DONE. Otherwise row++ and go to FETCH.
- DONE: done=1 each cycle. When start=0, go to IDLE. err holds until the next start.
- dp_vector_b_flat and dp_vector_length are stable from CHECK until the next start.
- Per-row latency: vec_len+2 cycles of fetch plus handshake, plus the dot_product time, plus 1 EMIT cycle.
- An X-free w_rd_data is only required in capture cycles.

Decomposition:
- Shared package: state encodings (IDLE..DONE, 4-bit), DATA_WIDTH/MAX_VECTOR_SIZE defaults, and a length-check constant shared with dot_product.
- One sub-module: row_packer. It holds the write-index register, 1-cycle read-valid delay and slot write into the flat vector, with clear. The FSM and handshake stay in the top.

Test Plan:
- Single row: num_rows=1, vec_len=3, base=0x10, mem[0x10..0x12]=A,B,C -> reads at 0x10,0x11,0x12 only; dp_vector_a_flat={0,0,0,0,C,B,A}; one row_valid with row_index=0 carrying the dot-product model result; then done=1 until start drops.
- Multi-row addressing: num_rows=3, vec_len=7, base=0 -> read addresses 0..20 contiguous; three row_valid pulses with indices 0,1,2 in order.
- Address wrap: base=0xFE, vec_len=4, num_rows=1 -> addresses 0xFE,0xFF,0x00,0x01.
- Illegal lengths: vec_len=0, then vec_len=8, then num_rows=0 -> err=1 and done=1 within 2 cycles; w_rd_en and dp_start never assert.
- Slow handshake: a dot_product model that holds dp_done for 5 cycles after start falls -> no row_valid until dp_done=0; dp_start is never re-asserted early; start held high in DONE produces no restart.
- Reset mid-DP_WAIT with row=1 of 3 -> all outputs 0 immediately; a fresh start with new inputs completes correctly.
